sdram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the SDRAM_Interface controller. It shares the single 16-bit SDRAM request port between the ADC capture writer (port 0, latency-critical) and the host readout path (port 1). It latches the winning request and drives the controller's Req/WnR/Address/DataIn handshake. It tracks each transaction to completion and returns read data and completion pulses to the owning port. Sits between the capture/readout logic and SDRAM_Interface, all on the 100 MHz Clk domain.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_arb_select.sv | 50 +++++
 rtl/sdram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: state encoding, port
// indices and the bus widths used by SDRAM_Interface.
package sdram_arb_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    localparam logic PORT_ADC  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sdram_arb_select.sv
// Winner selection for the SDRAM arbiter: port 0 by default, port 1 once it
// has been passed over MAX_STARVE times in a row.
module sdram_arb_select
    import sdram_arb_pkg::*;
#(
    parameter int MAX_STARVE = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic grant_i,
    input  logic grant_idx_i,
    output logic winner_o
);

    localparam int              CNT_W      = $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    // Only port-0 grants that actually passed over a waiting port 1 count.
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            if (grant_idx_i == PORT_HOST) begin
                starve_d = '0;
            end else if (req1_i && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        winner_o = PORT_ADC;
        if (req1_i && (!req0_i || (starve_q == STARVE_MAX))) begin
            winner_o = PORT_HOST;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter/sequencer in front of SDRAM_Interface: grants one request
// at a time, drives the controller handshake and returns Ack/Done/Rdata.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MAX_STARVE = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              WnR0,
    input  logic              WnR1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata0,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Ack0,
    output logic              Ack1,
    output logic              Done0,
    output logic              Done1,
    output logic [DATA_W-1:0] Rdata,
    output logic              Err,
    output logic              MemReq,
    output logic              MemWnR,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata,
    input  logic              MemBusy,
    input  logic              MemAck
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_e state_q;
    arb_state_e state_d;

    logic              owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_wnr_q,   mem_wnr_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              err_q,       err_d;
    logic              ack0_q,      ack0_d;
    logic              ack1_q,      ack1_d;
    logic              done0_q,     done0_d;
    logic              done1_q,     done1_d;
    logic [WD_W-1:0]   wdog_q,      wdog_d;

    logic winner;
    logic grant;
    logic timeout;
    logic ack_hit;
    logic done_hit;

    assign grant   = (state_q == IDLE) && !MemBusy && (Req0 || Req1);
    assign timeout = ((state_q == ISSUE) || (state_q == WAIT_DONE)) && (wdog_q == WD_LAST);

    sdram_arb_select #(
        .MAX_STARVE (MAX_STARVE)
    ) u_select (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .req0_i      (Req0),
        .req1_i      (Req1),
        .grant_i     (grant),
        .grant_idx_i (winner),
        .winner_o    (winner)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The watchdog wins over a same-cycle Ack or Busy release so the error
    // always fires exactly TIMEOUT cycles after the request went out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (timeout) begin
                    state_d = IDLE;
                end else if (MemAck) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (timeout || !MemBusy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_wnr_d   = mem_wnr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wdog_d      = '0;
        ack_hit     = 1'b0;
        done_hit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d   = winner;
                    mem_req_d = 1'b1;
                    if (winner == PORT_HOST) begin
                        mem_wnr_d   = WnR1;
                        mem_addr_d  = Addr1;
                        mem_wdata_d = Wdata1;
                    end else begin
                        mem_wnr_d   = WnR0;
                        mem_addr_d  = Addr0;
                        mem_wdata_d = Wdata0;
                    end
                end
            end
            ISSUE: begin
                wdog_d = wdog_q + WD_W'(1);
                if (timeout) begin
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    rdata_d   = '0;
                    done_hit  = 1'b1;
                end else if (MemAck) begin
                    // Drop Req with the Ack so the controller cannot re-accept it.
                    mem_req_d = 1'b0;
                    ack_hit   = 1'b1;
                end
            end
            WAIT_DONE: begin
                wdog_d = wdog_q + WD_W'(1);
                if (timeout) begin
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    done_hit = 1'b1;
                end else if (!MemBusy) begin
                    if (!mem_wnr_q) begin
                        rdata_d = MemRdata;
                    end
                    done_hit = 1'b1;
                end
            end
            default: ;
        endcase

        ack0_d  = ack_hit  && (owner_q == PORT_ADC);
        ack1_d  = ack_hit  && (owner_q == PORT_HOST);
        done0_d = done_hit && (owner_q == PORT_ADC);
        done1_d = done_hit && (owner_q == PORT_HOST);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            owner_q     <= PORT_ADC;
            mem_req_q   <= 1'b0;
            mem_wnr_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            wdog_q      <= '0;
        end else begin
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_wnr_q   <= mem_wnr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            wdog_q      <= wdog_d;
        end
    end

    assign Ack0     = ack0_q;
    assign Ack1     = ack1_q;
    assign Done0    = done0_q;
    assign Done1    = done1_q;
    assign Rdata    = rdata_q;
    assign Err      = err_q;
    assign MemReq   = mem_req_q;
    assign MemWnR   = mem_wnr_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a behavioural SDRAM controller model
// and Ack/Done scoreboards.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int MAX_STARVE = 8;
    localparam int TIMEOUT    = 1024;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req0, Req1, WnR0, WnR1;
    logic [21:0] Addr0, Addr1;
    logic [15:0] Wdata0, Wdata1;
    logic        Ack0, Ack1, Done0, Done1, Err;
    logic [15:0] Rdata;
    logic        MemReq, MemWnR;
    logic [21:0] MemAddr;
    logic [15:0] MemWdata;
    logic [15:0] MemRdata;
    logic        MemBusy, MemAck;

    always #5 Clk = ~Clk;

    sdram_arbiter #(
        .MAX_STARVE (MAX_STARVE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Req0     (Req0),
        .Req1     (Req1),
        .WnR0     (WnR0),
        .WnR1     (WnR1),
        .Addr0    (Addr0),
        .Addr1    (Addr1),
        .Wdata0   (Wdata0),
        .Wdata1   (Wdata1),
        .Ack0     (Ack0),
        .Ack1     (Ack1),
        .Done0    (Done0),
        .Done1    (Done1),
        .Rdata    (Rdata),
        .Err      (Err),
        .MemReq   (MemReq),
        .MemWnR   (MemWnR),
        .MemAddr  (MemAddr),
        .MemWdata (MemWdata),
        .MemRdata (MemRdata),
        .MemBusy  (MemBusy),
        .MemAck   (MemAck)
    );

    // Controller model: optional refresh stall, Ack held two cycles, then busy.
    int unsigned refresh_len;
    int unsigned busy_len;
    logic        never_ack;
    logic [15:0] rd_value;
    int unsigned refresh_cnt, busy_left, ack_left;
    logic        m_active;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            MemAck      <= 1'b0;
            MemBusy     <= 1'b0;
            MemRdata    <= 16'h0;
            refresh_cnt <= 0;
            busy_left   <= 0;
            ack_left    <= 0;
            m_active    <= 1'b0;
        end else if (!m_active) begin
            MemAck <= 1'b0;
            if (MemReq && (refresh_cnt < refresh_len)) begin
                MemBusy     <= 1'b1;
                refresh_cnt <= refresh_cnt + 1;
            end else if (MemReq && !never_ack) begin
                MemAck      <= 1'b1;
                MemBusy     <= 1'b1;
                ack_left    <= 1;
                busy_left   <= busy_len;
                refresh_cnt <= 0;
                m_active    <= 1'b1;
            end else begin
                MemBusy <= 1'b0;
            end
        end else begin
            if (ack_left == 0) MemAck <= 1'b0;
            else ack_left <= ack_left - 1;
            if (busy_left == 0) begin
                MemBusy  <= 1'b0;
                MemRdata <= rd_value;
                m_active <= 1'b0;
            end else begin
                busy_left <= busy_left - 1;
            end
        end
    end

    typedef struct packed {
        logic        port;
        logic        chk;
        logic [15:0] rdata;
    } done_t;

    logic  ack_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ack_cnt = 0;
    int    base;
    logic  prev_ack0, prev_ack1, prev_done0, prev_done1;
    logic [1:0] outstanding;
    logic  stable;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_txn(input logic p, input logic chk, input logic [15:0] rd);
        done_t d;
        d.port  = p;
        d.chk   = chk;
        d.rdata = rd;
        ack_q.push_back(p);
        done_q.push_back(d);
    endtask

    task automatic monitor();
        done_t d;
        logic  ap;
        if (Ack0 || Ack1) begin
            check("ack_one_hot", 32'(Ack0 & Ack1), 0);
            check("ack_single_cycle", 32'((Ack0 & prev_ack0) | (Ack1 & prev_ack1)), 0);
            check("ack_expected", 32'(ack_q.size() != 0), 1);
            if (ack_q.size() != 0) begin
                ap = ack_q.pop_front();
                check("ack_port", 32'(Ack1), 32'(ap));
            end
            ack_cnt++;
        end
        if (Done0 || Done1) begin
            check("done_one_hot", 32'(Done0 & Done1), 0);
            check("done_single_cycle", 32'((Done0 & prev_done0) | (Done1 & prev_done1)), 0);
            check("done_expected", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                check("done_port", 32'(Done1), 32'(d.port));
                if (d.chk) check("done_rdata", 32'(Rdata), 32'(d.rdata));
            end
            outstanding[Done1] = 1'b0;
        end
        prev_ack0  = Ack0;
        prev_ack1  = Ack1;
        prev_done0 = Done0;
        prev_done1 = Done1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        monitor();
    endtask

    task automatic raise(input logic p, input logic wnr, input logic [21:0] a, input logic [15:0] w);
        check("req_before_done", 32'(outstanding[p]), 0);
        outstanding[p] = 1'b1;
        if (p) begin
            Req1 = 1'b1; WnR1 = wnr; Addr1 = a; Wdata1 = w;
        end else begin
            Req0 = 1'b1; WnR0 = wnr; Addr0 = a; Wdata0 = w;
        end
    endtask

    task automatic drop(input logic p);
        if (p) Req1 = 1'b0;
        else Req0 = 1'b0;
    endtask

    task automatic wait_ack(input int target, input int max_cycles);
        int n = 0;
        while ((ack_cnt < target) && (n < max_cycles)) begin
            tick();
            n++;
        end
        check("ack_within_bound", 32'(ack_cnt >= target), 1);
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while ((done_q.size() != 0) && (n < max_cycles)) begin
            tick();
            n++;
        end
        check("done_within_bound", 32'(done_q.size()), 0);
    endtask

    task automatic run_single(input logic p, input logic wnr, input logic [21:0] a,
                              input logic [15:0] w, input logic chk, input logic [15:0] rd);
        int b;
        b = ack_cnt;
        push_txn(p, chk, rd);
        raise(p, wnr, a, w);
        wait_ack(b + 1, 100);
        drop(p);
        wait_done(100);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench stopped");
    end

    initial begin
        Reset_n = 1'b0;
        Req0 = 0; Req1 = 0; WnR0 = 0; WnR1 = 0;
        Addr0 = '0; Addr1 = '0; Wdata0 = '0; Wdata1 = '0;
        refresh_len = 0; busy_len = 3; never_ack = 1'b0; rd_value = 16'h0;
        outstanding = '0;
        prev_ack0 = 0; prev_ack1 = 0; prev_done0 = 0; prev_done1 = 0;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_memreq", 32'(MemReq), 0);
        check("rst_memaddr", 32'(MemAddr), 0);
        check("rst_memwdata", 32'(MemWdata), 0);
        check("rst_ack_done", 32'({Ack0, Ack1, Done0, Done1}), 0);
        check("rst_err", 32'(Err), 0);
        Reset_n = 1'b1;
        tick();
        tick();

        // Single write on port 0
        push_txn(PORT_ADC, 1'b0, 16'h0);
        raise(1'b0, 1'b1, 22'h012345, 16'hA5A5);
        tick();
        check("t1_memreq_rise", 32'(MemReq), 1);
        check("t1_memaddr", 32'(MemAddr), 32'h012345);
        check("t1_memwdata", 32'(MemWdata), 32'hA5A5);
        check("t1_memwnr", 32'(MemWnR), 1);
        tick();
        check("t1_ack0_early", 32'(Ack0), 0);
        check("t1_memreq_hold", 32'(MemReq), 1);
        tick();
        check("t1_ack0", 32'(Ack0), 1);
        check("t1_memreq_drop", 32'(MemReq), 0);
        drop(1'b0);
        wait_done(50);
        $display("txn write p0 addr=012345 acks=%0d", ack_cnt);

        // Read on port 1
        rd_value = 16'h3C3C;
        run_single(1'b1, 1'b0, 22'h2ABCDE, 16'h0, 1'b1, 16'h3C3C);
        check("t2_rdata_hold", 32'(Rdata), 32'h3C3C);
        $display("txn read p1 addr=2ABCDE rdata=%h", Rdata);

        // Both ports held: 8 port-0 grants, one port-1, then again
        rd_value = 16'h0;
        for (int i = 0; i < 18; i++) push_txn((i == 8) || (i == 17), 1'b0, 16'h0);
        base = ack_cnt;
        raise(1'b0, 1'b1, 22'h000100, 16'h1111);
        raise(1'b1, 1'b1, 22'h000200, 16'h2222);
        wait_ack(base + 18, 18 * 20);
        drop(1'b0);
        drop(1'b1);
        wait_done(100);
        $display("txn starvation grants=%0d", ack_cnt - base);

        // Refresh collision
        refresh_len = 50;
        push_txn(PORT_ADC, 1'b0, 16'h0);
        base = ack_cnt;
        raise(1'b0, 1'b1, 22'h3FFFFF, 16'hBEEF);
        tick();
        check("t4_memreq_rise", 32'(MemReq), 1);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ((MemReq !== 1'b1) || (MemAddr !== 22'h3FFFFF) ||
                (MemWdata !== 16'hBEEF) || (Ack0 !== 1'b0)) stable = 1'b0;
        end
        check("t4_hold_during_refresh", 32'(stable), 1);
        refresh_len = 0;
        wait_ack(base + 1, 20);
        drop(1'b0);
        wait_done(50);
        check("t4_no_err", 32'(Err), 0);
        $display("txn refresh write p0 addr=3FFFFF err=%b", Err);

        // Timeout: controller never acks
        never_ack = 1'b1;
        done_q.push_back('{port: PORT_ADC, chk: 1'b1, rdata: 16'h0000});
        raise(1'b0, 1'b0, 22'h000777, 16'h0);
        tick();
        check("t5_memreq_rise", 32'(MemReq), 1);
        stable = 1'b1;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            if ((MemReq !== 1'b1) || (Err !== 1'b0) || (Done0 !== 1'b0)) stable = 1'b0;
        end
        check("t5_wait_no_err", 32'(stable), 1);
        tick();
        check("t5_err", 32'(Err), 1);
        check("t5_memreq_drop", 32'(MemReq), 0);
        check("t5_done0", 32'(Done0), 1);
        check("t5_rdata_zero", 32'(Rdata), 0);
        drop(1'b0);
        never_ack = 1'b0;
        wait_done(5);
        rd_value = 16'h1234;
        run_single(1'b0, 1'b0, 22'h000010, 16'h0, 1'b1, 16'h1234);
        check("t5_err_sticky", 32'(Err), 1);
        $display("txn timeout p0 err=%b then read rdata=%h", Err, Rdata);

        // Asynchronous reset during WAIT_DONE
        ack_q.push_back(PORT_ADC);
        base = ack_cnt;
        raise(1'b0, 1'b1, 22'h0ABCDE, 16'hCAFE);
        wait_ack(base + 1, 20);
        drop(1'b0);
        tick();
        #3;
        Reset_n = 1'b0;
        #1;
        check("t6_rst_memreq", 32'(MemReq), 0);
        check("t6_rst_memaddr", 32'(MemAddr), 0);
        check("t6_rst_memwdata", 32'(MemWdata), 0);
        check("t6_rst_memwnr", 32'(MemWnR), 0);
        check("t6_rst_err", 32'(Err), 0);
        check("t6_rst_rdata", 32'(Rdata), 0);
        check("t6_rst_pulses", 32'({Ack0, Ack1, Done0, Done1}), 0);
        outstanding = '0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        push_txn(PORT_ADC, 1'b0, 16'h0);
        base = ack_cnt;
        raise(1'b0, 1'b1, 22'h000042, 16'h0F0F);
        tick();
        check("t6_grant_after_reset", 32'(MemReq), 1);
        check("t6_addr_after_reset", 32'(MemAddr), 32'h000042);
        wait_ack(base + 1, 20);
        drop(1'b0);
        wait_done(50);
        check("t6_no_err", 32'(Err), 0);
        $display("txn reset-recovery write p0 addr=000042 err=%b", Err);

        check("ack_queue_drained", 32'(ack_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
